// File: rtl/tt_user_project_wrapper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tt_user_project_wrapper_if                                     |
// | Brief    : User pad bundle (pad inputs, pad outputs, output-enable bars). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface tt_user_project_wrapper_if #(
    parameter int MPRJ_IO_PADS = 38
);
    logic [MPRJ_IO_PADS-1:0] io_in;
    logic [MPRJ_IO_PADS-1:0] io_out;
    logic [MPRJ_IO_PADS-1:0] io_oeb;

    // The pad ring is the master: it drives io_in and observes io_out/io_oeb.
    modport master (output io_in, input io_out, input io_oeb);
    modport slave  (input io_in, output io_out, output io_oeb);
endinterface
`default_nettype wire

// File: rtl/tt_user_project_wrapper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tt_user_project_wrapper                                        |
// | Brief    : User-area mux of 4 demo projects routed to fixed pad slices.   |
// |            USE_POWER_PINS_EN adds vccd1/vssd1 hookup ports.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tt_user_project_wrapper #(
    parameter int MPRJ_IO_PADS = 38,
    parameter int ADDR_W       = 4
) (
`ifdef USE_POWER_PINS_EN
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  wire logic             clk,
    input  wire logic             reset,
    tt_user_project_wrapper_if.slave pads
);
    // Synchronized control vector bit positions
    localparam int c_uclk   = 0;
    localparam int c_urst_n = 1;
    localparam int c_ena    = 2;
    localparam int c_inc    = 3;
    localparam int c_srst_n = 4;

    logic [4:0]              sync1_q, sync1_d;
    logic [4:0]              sync2_q, sync2_d;
    logic [4:0]              prev_q,  prev_d;
    logic [ADDR_W-1:0]       sel_q,   sel_d;
    logic [7:0]              cnt_q,   cnt_d;
    logic [MPRJ_IO_PADS-1:0] io_out_q, io_out_d;
    logic [MPRJ_IO_PADS-1:0] io_oeb_q, io_oeb_d;

    logic [4:0] w_rise;
    logic       w_active;
    logic [7:0] w_ui_in, w_uio_in, w_uo, w_uio_out, w_uio_oe;

    assign w_ui_in  = pads.io_in[15:8];
    assign w_uio_in = pads.io_in[31:24];

    always_comb begin
        sync1_d = {pads.io_in[36], pads.io_in[34], pads.io_in[32], pads.io_in[7], pads.io_in[6]};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        w_rise  = sync2_q & ~prev_q;

        sel_d = sel_q;
        if (!sync2_q[c_srst_n]) begin
            sel_d = '0;
        end else if (w_rise[c_inc]) begin
            sel_d = sel_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (!sync2_q[c_urst_n] || (sel_q != ADDR_W'(1))) begin
            cnt_d = 8'h00;
        end else if (w_rise[c_uclk]) begin
            cnt_d = cnt_q + 8'h01;
        end

        w_active  = sync2_q[c_ena] && (int'(sel_q) < 4);
        w_uo      = 8'h00;
        w_uio_out = 8'h00;
        w_uio_oe  = 8'h00;
        if (w_active) begin
            case (sel_q[1:0])
                2'd0: w_uo = w_ui_in;
                2'd1: begin
                    w_uo      = cnt_q;
                    w_uio_out = ~cnt_q;
                    w_uio_oe  = 8'hFF;
                end
                2'd2: w_uo = w_ui_in + w_uio_in;
                default: begin
                    w_uo      = ~w_ui_in;
                    w_uio_out = w_ui_in;
                    w_uio_oe  = 8'hFF;
                end
            endcase
        end

        io_out_d        = '0;
        io_out_d[23:16] = w_uo;
        io_out_d[31:24] = w_uio_out & w_uio_oe;
        io_oeb_d        = '1;
        io_oeb_d[23:16] = 8'h00;
        io_oeb_d[31:24] = ~w_uio_oe;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            io_out_q <= '0;
            io_oeb_q <= '1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            io_out_q <= io_out_d;
            io_oeb_q <= io_oeb_d;
        end
    end

    assign pads.io_out = io_out_q;
    assign pads.io_oeb = io_oeb_q;

    // Pads with no function in this wrapper
    logic unused_pads;
`ifdef USE_POWER_PINS_EN
    assign unused_pads = ^{pads.io_in[5:0], pads.io_in[33], pads.io_in[35],
                           pads.io_in[MPRJ_IO_PADS-1:37], vccd1, vssd1};
`else
    assign unused_pads = ^{pads.io_in[5:0], pads.io_in[33], pads.io_in[35],
                           pads.io_in[MPRJ_IO_PADS-1:37]};
`endif
endmodule
`default_nettype wire

// File: tb/tb_tt_user_project_wrapper.sv
`default_nettype none
// Directed bench for tt_user_project_wrapper with a per-cycle behavioural model.
module tb_tt_user_project_wrapper;
    localparam int PADS = 38;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tt_user_project_wrapper_if #(.MPRJ_IO_PADS(PADS)) pads ();

`ifdef USE_POWER_PINS_EN
    wire vccd1;
    wire vssd1;
    tt_user_project_wrapper #(.MPRJ_IO_PADS(PADS), .ADDR_W(4)) dut (
        .vccd1(vccd1), .vssd1(vssd1), .clk(clk), .reset(reset), .pads(pads));
`else
    tt_user_project_wrapper #(.MPRJ_IO_PADS(PADS), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .pads(pads));
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pad samples delayed by the synchronizer, sel/cnt as integers.
    logic [4:0]      d1, d2, d3, pad_now;
    int              m_sel, m_cnt, ui, uioin, uo, uio, oe;
    logic [PADS-1:0] exp_out, exp_oeb;

    always @(posedge clk) begin
        if (reset) begin
            d1 = '0; d2 = '0; d3 = '0;
            m_sel = 0; m_cnt = 0;
            exp_out = '0; exp_oeb = '1;
        end else begin
            ui    = int'(pads.io_in[15:8]);
            uioin = int'(pads.io_in[31:24]);
            uo = 0; uio = 0; oe = 0;
            if (d2[2] && m_sel < 4) begin
                case (m_sel)
                    0: uo = ui;
                    1: begin uo = m_cnt; uio = 255 - m_cnt; oe = 255; end
                    2: uo = (ui + uioin) % 256;
                    default: begin uo = 255 - ui; uio = ui; oe = 255; end
                endcase
            end
            exp_out = '0;
            exp_out[23:16] = uo[7:0];
            exp_out[31:24] = uio[7:0] & oe[7:0];
            exp_oeb = '1;
            exp_oeb[23:16] = 8'h00;
            exp_oeb[31:24] = ~oe[7:0];
            if (!d2[1] || m_sel != 1)   m_cnt = 0;
            else if (d2[0] && !d3[0])   m_cnt = (m_cnt + 1) % 256;
            if (!d2[4])                 m_sel = 0;
            else if (d2[3] && !d3[3])   m_sel = (m_sel + 1) % 16;
            pad_now = {pads.io_in[36], pads.io_in[34], pads.io_in[32], pads.io_in[7], pads.io_in[6]};
            d3 = d2; d2 = d1; d1 = pad_now;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_io_out", 64'(pads.io_out), 64'(exp_out));
            chk("model_io_oeb", 64'(pads.io_oeb), 64'(exp_oeb));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pad(input int i, input logic v);
        pads.io_in[i] = v;
    endtask

    task automatic pulse(input int i);
        set_pad(i, 1'b1); step(4);
        set_pad(i, 1'b0); step(4);
    endtask

    initial begin
        pads.io_in = '0;
        reset = 1'b1;
        step(1);
        checking = 1'b1;
        step(1);
        chk("reset_io_out", 64'(pads.io_out), 64'h0);
        chk("reset_io_oeb", 64'(pads.io_oeb), 64'h3F_FFFF_FFFF);
        chk("reset_sel",    64'(dut.sel_q),   64'h0);
        reset = 1'b0;

        // select 0, pass-through
        set_pad(36, 1'b1); set_pad(32, 1'b1);
        pads.io_in[15:8] = 8'hA5;
        step(4);
        chk("pass_uo",  64'(pads.io_out[23:16]), 64'hA5);
        chk("pass_oeb", 64'(pads.io_oeb[31:24]), 64'hFF);

        // sel 2, adder
        pads.io_in[15:8]  = 8'hF0;
        pads.io_in[31:24] = 8'h20;
        pulse(34); pulse(34);
        chk("adder_uo", 64'(pads.io_out[23:16]), 64'h10);

        // sel 1, counter
        set_pad(36, 1'b0); step(4); set_pad(36, 1'b1); step(4);
        pulse(34);
        set_pad(7, 1'b0); step(4); set_pad(7, 1'b1); step(4);
        repeat (5) begin
            set_pad(6, 1'b1); step(3); set_pad(6, 1'b0); step(3);
        end
        step(4);
        chk("cnt_uo",  64'(pads.io_out[23:16]), 64'h05);
        chk("cnt_uio", 64'(pads.io_out[31:24]), 64'hFA);
        chk("cnt_oeb", 64'(pads.io_oeb[31:24]), 64'h00);

        // sel 3, invert; then disable
        pulse(34); pulse(34);
        chk("inv_uo",  64'(pads.io_out[23:16]), 64'h0F);
        chk("inv_uio", 64'(pads.io_out[31:24]), 64'hF0);
        set_pad(32, 1'b0); step(4);
        chk("dis_out", 64'(pads.io_out[31:16]), 64'h0);
        chk("dis_oeb", 64'(pads.io_oeb[31:24]), 64'hFF);
        set_pad(32, 1'b1); step(4);
        chk("reen_uo", 64'(pads.io_out[23:16]), 64'h0F);

        // out of range sel 7
        repeat (4) pulse(34);
        chk("oor_out", 64'(pads.io_out[31:16]), 64'h0);
        chk("oor_oeb", 64'(pads.io_oeb[31:24]), 64'hFF);

        // wrap: 16 increments from 0 lands back on 0
        set_pad(36, 1'b0); step(4); set_pad(36, 1'b1); step(4);
        pads.io_in[15:8] = 8'h3C;
        repeat (16) pulse(34);
        chk("wrap_uo", 64'(pads.io_out[23:16]), 64'h3C);

        // reset mid-operation
        reset = 1'b1;
        step(1);
        chk("midrst_out", 64'(pads.io_out), 64'h0);
        chk("midrst_oeb", 64'(pads.io_oeb), 64'h3F_FFFF_FFFF);
        reset = 1'b0;
        step(2);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
